// File: rtl/store_buffer_if.sv
// rtl/store_buffer_if.sv - CPU/memory-side signal bundle for the store buffer
//
// Purpose: groups the store, drain, load-lookup and occupancy signals of the
// store buffer so the buffer and its neighbours connect with one port.
// Ports (signals):
//   store side : st_valid, st_addr, st_data, st_pc -> st_ready
//   drain side : drain_en -> DMWr, A, WD, PC
//   load side  : ld_valid, ld_addr -> fwd_hit, fwd_data, ld_stall
//   status     : count (occupied entries, $clog2(DEPTH)+1 bits)
// Modports: master = CPU / memory side, slave = store buffer.
interface store_buffer_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          st_valid;
    logic [31:0]   st_addr;
    logic [31:0]   st_data;
    logic [31:0]   st_pc;
    logic          st_ready;
    logic          drain_en;
    logic          DMWr;
    logic [31:0]   A;
    logic [31:0]   WD;
    logic [31:0]   PC;
    logic          ld_valid;
    logic [31:0]   ld_addr;
    logic          fwd_hit;
    logic [31:0]   fwd_data;
    logic          ld_stall;
    logic [CW-1:0] count;

    modport master (
        output st_valid, st_addr, st_data, st_pc, drain_en, ld_valid, ld_addr,
        input  st_ready, DMWr, A, WD, PC, fwd_hit, fwd_data, ld_stall, count
    );

    modport slave (
        input  st_valid, st_addr, st_data, st_pc, drain_en, ld_valid, ld_addr,
        output st_ready, DMWr, A, WD, PC, fwd_hit, fwd_data, ld_stall, count
    );
endinterface

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - FIFO store buffer with load lookup/forwarding
//
// Purpose: queues CPU stores as {addr, data, pc} and writes them to data
// memory one per cycle, oldest first, whenever the memory port is free.
// Loads are looked up combinationally against the queued stores.
// Ports:
//   CLK   : clock, rising edge
//   Reset : asynchronous, active-high; empties the buffer immediately
//   bus   : store_buffer_if.slave (store, drain, lookup, count signals)
// Parameter DEPTH: entries, power of two 2..16.
// Optional feature macro SB_FWD_EN: when defined, matching loads are
// forwarded (fwd_hit/fwd_data); otherwise a matching load raises ld_stall.
module store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic           CLK,
    input  logic           Reset,
    store_buffer_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   e_addr [DEPTH];
    logic [31:0]   e_data [DEPTH];
    logic [31:0]   e_pc   [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] cnt;

    logic          not_empty;
    logic          full;
    logic          drain;
    logic          ready;
    logic          push;

    assign not_empty = (cnt != '0);
    assign full      = (cnt == CW'(DEPTH));
    assign drain     = bus.drain_en && not_empty;
    // A full buffer still accepts a store when the head retires this cycle.
    assign ready     = !full || drain;
    assign push      = bus.st_valid && ready;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                e_addr[i] <= '0;
                e_data[i] <= '0;
                e_pc[i]   <= '0;
            end
        end else begin
            if (push) begin
                e_addr[tail] <= bus.st_addr;
                e_data[tail] <= bus.st_data;
                e_pc[tail]   <= bus.st_pc;
                tail         <= tail + PW'(1);
            end
            if (drain) begin
                head <= head + PW'(1);
            end
            case ({push, drain})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    assign bus.st_ready = ready;
    assign bus.count    = cnt;
    assign bus.DMWr     = drain;
    assign bus.A        = not_empty ? e_addr[head] : 32'h0;
    assign bus.WD       = not_empty ? e_data[head] : 32'h0;
    assign bus.PC       = not_empty ? e_pc[head]   : 32'h0;

    // Walk from oldest to youngest so a later match overrides an earlier one:
    // the youngest matching store supplies the data. Only registered entries
    // are searched, which includes a head being drained this cycle and
    // excludes a store being pushed this cycle.
    logic          match;
    logic [31:0]   match_data;
    logic [PW-1:0] idx;

    always_comb begin
        match      = 1'b0;
        match_data = 32'h0;
        idx        = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if (bus.ld_valid && (CW'(i) < cnt) &&
                (e_addr[idx][11:2] == bus.ld_addr[11:2])) begin
                match      = 1'b1;
                match_data = e_data[idx];
            end
        end
    end

    // Loads compare on the word index only.
    logic unused_ld_bits;
    assign unused_ld_bits = ^{bus.ld_addr[31:12], bus.ld_addr[1:0]};

`ifdef SB_FWD_EN
    assign bus.fwd_hit  = match;
    assign bus.fwd_data = match_data;
    assign bus.ld_stall = 1'b0;
`else
    assign bus.fwd_hit  = 1'b0;
    assign bus.fwd_data = 32'h0;
    assign bus.ld_stall = match;

    logic unused_match_data;
    assign unused_match_data = ^match_data;
`endif
endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - self-checking bench for store_buffer (DEPTH=4)
module tb_store_buffer;
    logic CLK;
    logic Reset;

    store_buffer_if #(.DEPTH(4)) bus();

    store_buffer #(.DEPTH(4)) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] p;
    } ent_t;
    ent_t mq[$];

    typedef struct {
        logic        sv;
        logic [31:0] sa;
        logic [31:0] sd;
        logic        de;
        logic        lv;
        logic [31:0] la;
        int          cnt;
        logic        rdy;
        logic        dmwr;
        logic [31:0] a;
        logic [31:0] wd;
        logic        m;
        logic [31:0] md;
    } vec_t;
    vec_t vq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                         input logic [31:0] sp, input logic de, input logic lv,
                         input logic [31:0] la);
        bus.st_valid = sv;
        bus.st_addr  = sa;
        bus.st_data  = sd;
        bus.st_pc    = sp;
        bus.drain_en = de;
        bus.ld_valid = lv;
        bus.ld_addr  = la;
    endtask

    task automatic check_all(input string tag, input int cnt, input logic rdy,
                             input logic dmwr, input logic [31:0] a, input logic [31:0] wd,
                             input logic [31:0] pc, input logic m, input logic [31:0] md);
        chk({tag, ".count"}, 32'(bus.count), 32'(cnt));
        chk({tag, ".st_ready"}, 32'(bus.st_ready), 32'(rdy));
        chk({tag, ".DMWr"}, 32'(bus.DMWr), 32'(dmwr));
        chk({tag, ".A"}, bus.A, a);
        chk({tag, ".WD"}, bus.WD, wd);
        chk({tag, ".PC"}, bus.PC, pc);
`ifdef SB_FWD_EN
        chk({tag, ".fwd_hit"}, 32'(bus.fwd_hit), 32'(m));
        chk({tag, ".fwd_data"}, bus.fwd_data, md);
        chk({tag, ".ld_stall"}, 32'(bus.ld_stall), 32'h0);
`else
        chk({tag, ".fwd_hit"}, 32'(bus.fwd_hit), 32'h0);
        chk({tag, ".fwd_data"}, bus.fwd_data, 32'h0);
        chk({tag, ".ld_stall"}, 32'(bus.ld_stall), 32'(m));
`endif
    endtask

    // Reference: a queue in program order; head is mq[0], youngest is last.
    task automatic model_check(input string tag);
        int          n;
        logic        rdy, dmwr, m;
        logic [31:0] a, wd, pc, md;
        n    = mq.size();
        dmwr = bus.drain_en && (n != 0);
        rdy  = (n < 4) || dmwr;
        a    = (n != 0) ? mq[0].a : 32'h0;
        wd   = (n != 0) ? mq[0].d : 32'h0;
        pc   = (n != 0) ? mq[0].p : 32'h0;
        m    = 1'b0;
        md   = 32'h0;
        if (bus.ld_valid) begin
            for (int i = n - 1; i >= 0; i--) begin
                if (mq[i].a[11:2] == bus.ld_addr[11:2]) begin
                    m  = 1'b1;
                    md = mq[i].d;
                    break;
                end
            end
        end
        check_all(tag, n, rdy, dmwr, a, wd, pc, m, md);
    endtask

    task automatic model_edge();
        int   n;
        logic dmwr, rdy;
        ent_t e;
        n    = mq.size();
        dmwr = bus.drain_en && (n != 0);
        rdy  = (n < 4) || dmwr;
        if (dmwr) void'(mq.pop_front());
        if (bus.st_valid && rdy) begin
            e.a = bus.st_addr;
            e.d = bus.st_data;
            e.p = bus.st_pc;
            mq.push_back(e);
        end
    endtask

    task automatic finish_cycle();
        @(posedge CLK);
        model_edge();
        @(negedge CLK);
    endtask

    task automatic row(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                       input logic de, input logic lv, input logic [31:0] la,
                       input int cnt, input logic rdy, input logic dmwr,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic m, input logic [31:0] md);
        vec_t v;
        v.sv = sv; v.sa = sa; v.sd = sd; v.de = de; v.lv = lv; v.la = la;
        v.cnt = cnt; v.rdy = rdy; v.dmwr = dmwr; v.a = a; v.wd = wd;
        v.m = m; v.md = md;
        vq.push_back(v);
    endtask

    localparam logic [31:0] PCOFS = 32'h4000_0000;

    initial begin
        vec_t v;
        logic [31:0] ra, la;

        //   sv  st_addr  st_data       de  lv  ld_addr      cnt rdy dmwr A      WD            m  md
        row(1, 32'h010, 32'hAAAA0001, 0, 0, 32'h0,       0, 1, 0, 32'h0,   32'h0,        0, 0);
        row(0, 32'h0,   32'h0,        1, 0, 32'h0,       1, 1, 1, 32'h010, 32'hAAAA0001, 0, 0);
        row(0, 32'h0,   32'h0,        0, 0, 32'h0,       0, 1, 0, 32'h0,   32'h0,        0, 0);
        row(1, 32'h100, 32'h1,        0, 0, 32'h0,       0, 1, 0, 32'h0,   32'h0,        0, 0);
        row(1, 32'h104, 32'h2,        0, 0, 32'h0,       1, 1, 0, 32'h100, 32'h1,        0, 0);
        row(1, 32'h108, 32'h3,        0, 0, 32'h0,       2, 1, 0, 32'h100, 32'h1,        0, 0);
        row(1, 32'h10C, 32'h4,        0, 0, 32'h0,       3, 1, 0, 32'h100, 32'h1,        0, 0);
        row(1, 32'h110, 32'h5,        0, 0, 32'h0,       4, 0, 0, 32'h100, 32'h1,        0, 0);
        row(1, 32'h110, 32'h5,        1, 0, 32'h0,       4, 1, 1, 32'h100, 32'h1,        0, 0);
        row(0, 32'h0,   32'h0,        1, 0, 32'h0,       4, 1, 1, 32'h104, 32'h2,        0, 0);
        row(0, 32'h0,   32'h0,        1, 0, 32'h0,       3, 1, 1, 32'h108, 32'h3,        0, 0);
        row(0, 32'h0,   32'h0,        1, 0, 32'h0,       2, 1, 1, 32'h10C, 32'h4,        0, 0);
        row(0, 32'h0,   32'h0,        1, 0, 32'h0,       1, 1, 1, 32'h110, 32'h5,        0, 0);
        row(1, 32'h020, 32'h1,        0, 0, 32'h0,       0, 1, 0, 32'h0,   32'h0,        0, 0);
        row(1, 32'h020, 32'h2,        0, 0, 32'h0,       1, 1, 0, 32'h020, 32'h1,        0, 0);
        row(0, 32'h0,   32'h0,        0, 1, 32'h022,     2, 1, 0, 32'h020, 32'h1,        1, 32'h2);
        row(0, 32'h0,   32'h0,        1, 1, 32'h022,     2, 1, 1, 32'h020, 32'h1,        1, 32'h2);
        row(0, 32'h0,   32'h0,        1, 1, 32'h1022,    1, 1, 1, 32'h020, 32'h2,        1, 32'h2);
        row(0, 32'h0,   32'h0,        0, 1, 32'h022,     0, 1, 0, 32'h0,   32'h0,        0, 0);
        row(1, 32'h030, 32'h5,        0, 1, 32'h030,     0, 1, 0, 32'h0,   32'h0,        0, 0);
        row(0, 32'h0,   32'h0,        0, 1, 32'h030,     1, 1, 0, 32'h030, 32'h5,        1, 32'h5);
        row(1, 32'h040, 32'h6,        1, 0, 32'h030,     1, 1, 1, 32'h030, 32'h5,        0, 0);
        row(0, 32'h0,   32'h0,        0, 0, 32'h0,       1, 1, 0, 32'h040, 32'h6,        0, 0);
        row(0, 32'h0,   32'h0,        1, 0, 32'h0,       1, 1, 1, 32'h040, 32'h6,        0, 0);
        row(0, 32'h0,   32'h0,        0, 0, 32'h0,       0, 1, 0, 32'h0,   32'h0,        0, 0);

        // Reset state, with requests present on every input.
        Reset = 1'b1;
        apply(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0);
        #2;
        check_all("reset", 0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
        @(negedge CLK);
        Reset = 1'b0;
        apply(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);

        // Directed vector table.
        for (int i = 0; i < vq.size(); i++) begin
            v = vq[i];
            apply(v.sv, v.sa, v.sd, v.sa + PCOFS, v.de, v.lv, v.la);
            #1;
            check_all($sformatf("vec%0d", i), v.cnt, v.rdy, v.dmwr, v.a, v.wd,
                      (v.cnt != 0) ? v.a + PCOFS : 32'h0, v.m, v.md);
            finish_cycle();
        end

        // Wrap-around: ten push-then-drain pairs must drain in push order.
        for (int i = 0; i < 10; i++) begin
            apply(1'b1, 32'h200 + 32'(4 * i), 32'(i), 32'h0, 1'b0, 1'b0, 32'h0);
            #1;
            chk($sformatf("wrap%0d.count_before", i), 32'(bus.count), 32'h0);
            finish_cycle();
            apply(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
            #1;
            chk($sformatf("wrap%0d.DMWr", i), 32'(bus.DMWr), 32'h1);
            chk($sformatf("wrap%0d.A", i), bus.A, 32'h200 + 32'(4 * i));
            finish_cycle();
        end
        apply(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        #1;
        chk("wrap.count_end", 32'(bus.count), 32'h0);
        finish_cycle();

        // Asynchronous reset with three stores pending and a drain under way.
        for (int i = 0; i < 3; i++) begin
            apply(1'b1, 32'h300 + 32'(4 * i), 32'h50 + 32'(i), 32'h0, 1'b0, 1'b0, 32'h0);
            finish_cycle();
        end
        apply(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
        #1;
        chk("areset.count_before", 32'(bus.count), 32'h3);
        chk("areset.DMWr_before", 32'(bus.DMWr), 32'h1);
        #2;
        Reset = 1'b1;
        #1;
        chk("areset.count", 32'(bus.count), 32'h0);
        chk("areset.DMWr", 32'(bus.DMWr), 32'h0);
        chk("areset.A", bus.A, 32'h0);
        chk("areset.st_ready", 32'(bus.st_ready), 32'h1);
        mq.delete();
        @(posedge CLK);
        @(negedge CLK);
        Reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("areset.post%0d.DMWr", i), 32'(bus.DMWr), 32'h0);
            chk($sformatf("areset.post%0d.count", i), 32'(bus.count), 32'h0);
            finish_cycle();
        end

        // Randomised traffic against the queue model; narrow word range forces hits.
        for (int i = 0; i < 400; i++) begin
            ra = ($urandom() & 32'hFFFF_F003) | (32'($urandom_range(0, 5)) << 2);
            la = ($urandom() & 32'hFFFF_F003) | (32'($urandom_range(0, 5)) << 2);
            apply(1'($urandom_range(0, 1)), ra, $urandom(), $urandom(),
                  1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)), la);
            #1;
            model_check($sformatf("rand%0d", i));
            finish_cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
